// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the instruction memory write port
module imem_loader #(
    parameter int DEPTH_WORDS = 2048
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        cpu_rst_no,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  err_code_o
);

    localparam int CW = $clog2(DEPTH_WORDS) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_lo_q;
    logic [15:0]     len_q;
    logic [7:0]      xor_q;
    logic [CW-1:0]   word_q;
    logic [CW-1:0]   word_inc;
    logic [1:0]      bcnt_q;
    logic [23:0]     asm_q;
    logic            accept;
    logic            idle_like;
    logic [15:0]     n_full;
    logic            len_bad;
    logic            last_word;
    logic            csum_ok;

    assign byte_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                          (state_q == S_DATA)   || (state_q == S_CSUM);
    assign accept    = byte_valid_i & byte_ready_o;
    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR);

    // Word count arrives low byte first; the high byte completes it on the LEN_HI accept.
    assign n_full    = {byte_data_i, len_lo_q};
    assign len_bad   = (n_full == 16'd0) || ({16'd0, n_full} > 32'(DEPTH_WORDS));
    assign word_inc  = word_q + 1'b1;
    assign last_word = (16'(word_inc) == len_q);
    assign csum_ok   = (byte_data_i == xor_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) state_d = len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (accept && (bcnt_q == 2'd3) && last_word) state_d = S_CSUM;
            end
            S_CSUM: begin
                if (accept) state_d = csum_ok ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_lo_q   <= 8'd0;
            len_q      <= 16'd0;
            xor_q      <= 8'd0;
            word_q     <= '0;
            bcnt_q     <= 2'd0;
            asm_q      <= 24'd0;
            we_o       <= 1'b0;
            waddr_o    <= 32'd0;
            wdata_o    <= 32'd0;
            cpu_rst_no <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            err_code_o <= 2'd0;
        end else begin
            we_o <= 1'b0;
            if (idle_like && start_i) begin
                done_o     <= 1'b0;
                error_o    <= 1'b0;
                err_code_o <= 2'd0;
                word_q     <= '0;
                bcnt_q     <= 2'd0;
                xor_q      <= 8'd0;
                cpu_rst_no <= 1'b0;
            end
            if (accept) begin
                case (state_q)
                    S_LEN_LO: begin
                        len_lo_q <= byte_data_i;
                        xor_q    <= xor_q ^ byte_data_i;
                    end
                    S_LEN_HI: begin
                        len_q <= n_full;
                        xor_q <= xor_q ^ byte_data_i;
                        if (len_bad) begin
                            error_o    <= 1'b1;
                            err_code_o <= 2'd1;
                        end
                    end
                    S_DATA: begin
                        xor_q  <= xor_q ^ byte_data_i;
                        bcnt_q <= bcnt_q + 2'd1;
                        // Bytes enter at the top so b0 ends up in the least significant lane.
                        asm_q  <= {byte_data_i, asm_q[23:8]};
                        if (bcnt_q == 2'd3) begin
                            we_o    <= 1'b1;
                            waddr_o <= {{(30 - CW){1'b0}}, word_q, 2'b00};
                            wdata_o <= {byte_data_i, asm_q};
                            word_q  <= word_inc;
                        end
                    end
                    S_CSUM: begin
                        if (csum_ok) begin
                            done_o     <= 1'b1;
                            cpu_rst_no <= 1'b1;
                        end else begin
                            error_o    <= 1'b1;
                            err_code_o <= 2'd2;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a frame-level model
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] wdata_o;
    logic        cpu_rst_no;
    logic        done_o;
    logic        error_o;
    logic [1:0]  err_code_o;

    always #5 clk_i = ~clk_i;

    imem_loader #(.DEPTH_WORDS(2048)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .cpu_rst_no   (cpu_rst_no),
        .done_o       (done_o),
        .error_o      (error_o),
        .err_code_o   (err_code_o)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_q[$];
    logic [7:0]  fr[$];
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame-level model: expected writes for the first nsent bytes plus the final verdict.
    task automatic model_frame(input int nsent);
        int         n;
        logic [7:0] x;
        wr_t        w;
        n = int'({fr[1], fr[0]});
        x = 8'd0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_code = 2'd0;
        if (n == 0 || n > 2048) begin
            exp_err  = 1'b1;
            exp_code = 2'd1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (2 + 4 * i + 3 < nsent) begin
                w.a = 32'(i * 4);
                w.d = {fr[2 + 4 * i + 3], fr[2 + 4 * i + 2], fr[2 + 4 * i + 1], fr[2 + 4 * i]};
                exp_q.push_back(w);
            end
        end
        for (int i = 0; i < 2 + 4 * n; i++) x ^= fr[i];
        if (fr[2 + 4 * n] == x) begin
            exp_done = 1'b1;
        end else begin
            exp_err  = 1'b1;
            exp_code = 2'd2;
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && we_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_we: got write addr %h data %h, required no write", waddr_o, wdata_o);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("waddr", waddr_o, w.a);
                chk("wdata", wdata_o, w.d);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        chk({tag, "_we"}, 32'(we_o), 32'd0);
        chk({tag, "_waddr"}, waddr_o, 32'd0);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_no), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_error"}, 32'(error_o), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code_o), 32'd0);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("ready_after_start", 32'(byte_ready_o), 32'd1);
        chk("cpu_rst_after_start", 32'(cpu_rst_no), 32'd0);
        chk("done_after_start", 32'(done_o), 32'd0);
        chk("error_after_start", 32'(error_o), 32'd0);
    endtask

    task automatic send_bytes(input int count, input int maxgap, input int start_at);
        for (int i = 0; i < count; i++) begin
            int t;
            t = 0;
            byte_data_i  = fr[i];
            byte_valid_i = 1'b1;
            while (byte_ready_o !== 1'b1 && t < 50) begin
                @(posedge clk_i); #1;
                t++;
            end
            if (t >= 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_timeout: got byte_ready_o low for 50 cycles at byte %0d, required high", i);
                byte_valid_i = 1'b0;
                return;
            end
            @(posedge clk_i); #1;
            byte_valid_i = 1'b0;
            if (maxgap > 0) begin
                repeat ($urandom_range(maxgap, 1)) begin
                    if (i == start_at) start_i = 1'b1;
                    @(posedge clk_i); #1;
                    start_i = 1'b0;
                end
            end
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_done"}, 32'(done_o), 32'(exp_done));
        chk({tag, "_error"}, 32'(error_o), 32'(exp_err));
        chk({tag, "_err_code"}, 32'(err_code_o), 32'(exp_code));
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_no), 32'(exp_done));
        chk({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_frame(input string tag, input int maxgap, input int start_at);
        model_frame(fr.size());
        do_start();
        send_bytes(fr.size(), maxgap, start_at);
        @(posedge clk_i); #1;
        check_status(tag);
    endtask

    task automatic load_case1(input logic [7:0] csum);
        fr = '{8'h02, 8'h00, 8'h93, 8'h07, 8'h20, 8'h03, 8'h13, 8'h00, 8'h00, 8'h00};
        fr.push_back(csum);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish within time limit, required finish");
        $fatal(1);
    end

    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'd0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset("por");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("idle_ready", 32'(byte_ready_o), 32'd0);

        // Pin the model with hand-computed words.
        load_case1(8'hA6);
        model_frame(fr.size());
        chk("model_w0_data", exp_q[0].d, 32'h03200793);
        chk("model_w1_data", exp_q[1].d, 32'h00000013);
        chk("model_w1_addr", exp_q[1].a, 32'h00000004);
        chk("model_done", 32'(exp_done), 32'd1);
        exp_q.delete();

        load_case1(8'hA6);
        run_frame("normal", 0, -1);
        chk("normal_done_lit", 32'(done_o), 32'd1);

        load_case1(8'hA7);
        run_frame("badcsum", 0, -1);
        chk("badcsum_code_lit", 32'(err_code_o), 32'd2);

        fr = '{8'h00, 8'h00};
        run_frame("len_zero", 0, -1);
        chk("len_zero_code_lit", 32'(err_code_o), 32'd1);

        fr = '{8'h01, 8'h08};
        run_frame("len_2049", 0, -1);

        load_case1(8'hA6);
        run_frame("gapped", 5, 5);

        load_case1(8'hA6);
        model_frame(7);
        do_start();
        send_bytes(7, 0, -1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        check_reset("midload_rst");
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("midload_writes_left", 32'(exp_q.size()), 32'd0);
        chk("after_rst_ready", 32'(byte_ready_o), 32'd0);

        load_case1(8'hA6);
        run_frame("after_rst", 0, -1);

        fr = '{8'h01, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00, 8'h62};
        model_frame(fr.size());
        chk("model_reload_data", exp_q[0].d, 32'h00100073);
        exp_q.delete();
        run_frame("reload", 0, -1);
        chk("reload_done_lit", 32'(done_o), 32'd1);

        repeat (2) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
